// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse position controller.
package mouse_pkg;

  typedef enum logic [1:0] {
    S_B0  = 2'd0,
    S_B1  = 2'd1,
    S_B2  = 2'd2,
    S_UPD = 2'd3
  } state_e;

  localparam int COORD_W = 11;
  localparam int SUM_W   = COORD_W + 1;

  // Byte0 bit positions
  localparam int BIT_L    = 0;
  localparam int BIT_R    = 1;
  localparam int BIT_M    = 2;
  localparam int BIT_SYNC = 3;
  localparam int BIT_XSGN = 4;
  localparam int BIT_YSGN = 5;
  localparam int BIT_XOVF = 6;
  localparam int BIT_YOVF = 7;

endpackage

// File: rtl/mouse_axis_acc.sv
// Combinational saturating accumulate for one axis: clamp(pos +/- delta, 0, max).
module mouse_axis_acc
  import mouse_pkg::*;
#(
  parameter bit INVERT = 1'b0
) (
  input  logic [COORD_W-1:0] pos_i,
  input  logic signed [8:0]  delta_i,
  input  logic [COORD_W-1:0] max_i,
  output logic [COORD_W-1:0] next_o
);

  logic signed [SUM_W-1:0] pos_s;
  logic signed [SUM_W-1:0] delta_ext_s;
  logic signed [SUM_W-1:0] delta_s;
  logic signed [SUM_W-1:0] sum_s;
  logic signed [SUM_W-1:0] max_s;

  // Negating in the wide domain keeps -(-256) representable.
  assign pos_s       = {1'b0, pos_i};
  assign max_s       = {1'b0, max_i};
  assign delta_ext_s = {{3{delta_i[8]}}, delta_i};
  assign delta_s     = INVERT ? -delta_ext_s : delta_ext_s;
  assign sum_s       = pos_s + delta_s;

  // Saturate into [0, max]
  always_comb begin
    if (sum_s < 12'sd0) begin
      next_o = {COORD_W{1'b0}};
    end else if (sum_s > max_s) begin
      next_o = max_i;
    end else begin
      next_o = sum_s[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/mouse_pos_ctrl.sv
// PS/2 mouse packet decoder: assembles 3-byte packets and updates a clamped sprite origin.
module mouse_pos_ctrl
  import mouse_pkg::*;
#(
  parameter int H_MAX   = 639,
  parameter int V_MAX   = 479,
  parameter int X_INIT  = 320,
  parameter int Y_INIT  = 240,
  parameter int TIMEOUT = 2_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_byte,
  input  logic               rx_valid,
  output logic [COORD_W-1:0] x0,
  output logic [COORD_W-1:0] y0,
  output logic [2:0]         btn,
  output logic               pkt_done,
  output logic               sync_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e state_q, state_d;
  logic [7:0]         b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [2:0]         btn_q, btn_d;
  logic               pkt_q, pkt_d, err_q, err_d;

  logic signed [8:0]  dx_s, dy_s;
  logic [COORD_W-1:0] x_next_s, y_next_s;

  assign dx_s = b0_q[BIT_XOVF] ? 9'sd0 : {b0_q[BIT_XSGN], b1_q};
  assign dy_s = b0_q[BIT_YOVF] ? 9'sd0 : {b0_q[BIT_YSGN], b2_q};

  mouse_axis_acc #(.INVERT(1'b0)) u_acc_x (
    .pos_i   (x_q),
    .delta_i (dx_s),
    .max_i   (COORD_W'(H_MAX)),
    .next_o  (x_next_s)
  );

  // Screen Y grows downward while PS/2 Y grows upward.
  mouse_axis_acc #(.INVERT(1'b1)) u_acc_y (
    .pos_i   (y_q),
    .delta_i (dy_s),
    .max_i   (COORD_W'(V_MAX)),
    .next_o  (y_next_s)
  );

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    cnt_d   = {CNT_W{1'b0}};
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    pkt_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_B0: begin
        if (rx_valid) begin
          if (rx_byte[BIT_SYNC]) begin
            b0_d    = rx_byte;
            state_d = S_B1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_B0;
        end
      end
      S_B1, S_B2: begin
        // A byte arriving on the expiry cycle still wins.
        if (rx_valid) begin
          if (state_q == S_B1) begin
            b1_d    = rx_byte;
            state_d = S_B2;
          end else begin
            b2_d    = rx_byte;
            state_d = S_UPD;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = S_B0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_UPD: begin
        state_d = S_B0;
        err_d   = rx_valid;
        if (b0_q[BIT_SYNC]) begin
          x_d   = x_next_s;
          y_d   = y_next_s;
          btn_d = {b0_q[BIT_M], b0_q[BIT_R], b0_q[BIT_L]};
          pkt_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = S_B0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_B0;
      b0_q    <= 8'h00;
      b1_q    <= 8'h00;
      b2_q    <= 8'h00;
      cnt_q   <= {CNT_W{1'b0}};
      x_q     <= COORD_W'(X_INIT);
      y_q     <= COORD_W'(Y_INIT);
      btn_q   <= 3'b000;
      pkt_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

  assign x0       = x_q;
  assign y0       = y_q;
  assign btn      = btn_q;
  assign pkt_done = pkt_q;
  assign sync_err = err_q;

endmodule

// File: tb/tb_mouse_pos_ctrl.sv
// Directed self-checking bench for mouse_pos_ctrl with a shortened timeout.
module tb_mouse_pos_ctrl;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [10:0] x0, y0;
  logic [2:0]  btn;
  logic        pkt_done, sync_err;

  int n_cmp = 0;
  int n_fail = 0;
  int n_pkt = 0;
  int n_err = 0;
  int pkt_base, err_base;

  mouse_pos_ctrl #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .x0       (x0),
    .y0       (y0),
    .btn      (btn),
    .pkt_done (pkt_done),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pkt_done) n_pkt++;
    if (sync_err) n_err++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send(b0);
    send(b1);
    send(b2);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey, input int eb);
    check({tag, "_x"}, int'(x0), ex);
    check({tag, "_y"}, int'(y0), ey);
    check({tag, "_btn"}, int'(btn), eb);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_pos("reset", 320, 240, 0);
    check("reset_pkt", int'(pkt_done), 0);
    check("reset_err", int'(sync_err), 0);
    rst_n = 1'b1;

    // First packet with latency and pulse-width checks
    send(8'h09);
    send(8'h10);
    @(negedge clk);
    rx_byte  = 8'h05;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("lat_e0_x", int'(x0), 320);
    check("lat_e0_pkt", int'(pkt_done), 0);
    @(posedge clk); #1;
    check_pos("pkt1", 336, 235, 1);
    check("lat_e1_pkt", int'(pkt_done), 1);
    @(posedge clk); #1;
    check("lat_e2_pkt", int'(pkt_done), 0);
    repeat (2) @(negedge clk);
    check("pkt1_npkt", n_pkt, 1);
    check("pkt1_nerr", n_err, 0);

    // Drive x toward 0 and clamp at the left edge
    packet(8'h18, 8'h00, 8'h00);
    check("x_m256", int'(x0), 80);
    packet(8'h18, 8'hB5, 8'h00);
    check("x_m75", int'(x0), 5);
    packet(8'h18, 8'hF0, 8'h00);
    check_pos("x_clamp0", 0, 235, 0);

    // Drive y to 470, then clamp at V_MAX
    packet(8'h28, 8'h00, 8'h15);
    check("y_470", int'(y0), 470);
    packet(8'h28, 8'h00, 8'hF6);
    check_pos("y_clamp", 0, 479, 0);

    // Out-of-sync byte in S_B0, then a good packet
    err_base = n_err;
    send(8'h00);
    repeat (2) @(negedge clk);
    check("bad_b0_err", n_err - err_base, 1);
    packet(8'h0B, 8'h05, 8'h00);
    check_pos("after_bad", 5, 479, 3);

    // Timeout between bytes
    err_base = n_err;
    pkt_base = n_pkt;
    send(8'h08);
    send(8'h10);
    repeat (TO - 3) @(negedge clk);
    check("to_early", n_err - err_base, 0);
    repeat (8) @(negedge clk);
    check("to_err", n_err - err_base, 1);
    check("to_npkt", n_pkt - pkt_base, 0);
    check_pos("to_hold", 5, 479, 3);
    packet(8'h0C, 8'h20, 8'h01);
    check_pos("after_to", 37, 478, 4);

    // Byte arriving during S_UPD is dropped
    err_base = n_err;
    send(8'h08);
    send(8'h01);
    @(negedge clk);
    rx_byte  = 8'h00;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_byte  = 8'h08;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("upd_drop_err", n_err - err_base, 1);
    check("upd_x", int'(x0), 38);
    packet(8'h09, 8'h02, 8'h03);
    check_pos("after_drop", 40, 475, 1);

    // X overflow forces dx to zero
    packet(8'h48, 8'h7F, 8'h01);
    check_pos("xovf", 40, 474, 0);

    // Reset asserted mid-packet
    send(8'h08);
    send(8'h10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_pos("mid_rst", 320, 240, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    packet(8'h09, 8'h10, 8'h05);
    check_pos("post_rst", 336, 235, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
